bounce_gen: RTL and testbench

BOUNCE_GEN -- requirements
Module: bounce_gen

---
 rtl/bounce_gen.sv | 160 ++++++++++++++++
 tb/tb_bounce_gen.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bounce_gen.sv
// Bouncy switch emulator: on a level command, chatters sw_o with
// LFSR-timed gaps, then holds the target level before signalling done.
module bounce_gen #(
  parameter int          ClkFreq  = 100_000_000,
  parameter int          BounceUs = 500,
  parameter int          SettleUs = 1000,
  parameter int          MinGap   = 4,
  parameter int          GapBits  = 8,
  parameter logic [15:0] Seed     = 16'hACE1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic cmd_valid_i,
  input  logic cmd_level_i,
  output logic cmd_ready_o,
  output logic sw_o,
  output logic busy_o,
  output logic done_tick_o
);

  localparam int BounceCycles = ClkFreq / 1_000_000 * BounceUs;
  localparam int SettleCycles = ClkFreq / 1_000_000 * SettleUs;
  localparam int GapMax = MinGap + (1 << GapBits) - 1;
  localparam int GapW = $clog2(GapMax + 1);
  localparam int WinW = $clog2(BounceCycles + 1);
  localparam int SetW = $clog2(SettleCycles + 1);

  localparam logic [WinW-1:0] WinLast = WinW'(BounceCycles - 1);
  localparam logic [SetW-1:0] SetLast = SetW'(SettleCycles);
  localparam logic [GapW-1:0] GapBase = GapW'(MinGap - 1);
  localparam logic [15:0] Poly = 16'hB400;
  localparam logic [15:0] SeedEff = (Seed == 16'h0) ? 16'h0001 : Seed;

  typedef enum logic [1:0] {
    IDLE,
    BOUNCE,
    SETTLE
  } state_e;

  state_e          r_state;
  state_e          w_state;
  logic            r_sw;
  logic            w_sw;
  logic            r_tgt;
  logic            w_tgt;
  logic            r_done;
  logic            w_done;
  logic [15:0]     r_lfsr;
  logic [15:0]     w_lfsr;
  logic [15:0]     w_lfsr_step;
  logic [GapW-1:0] r_gap;
  logic [GapW-1:0] w_gap;
  logic [GapW-1:0] w_gap_cur;
  logic [GapW-1:0] w_gap_nxt;
  logic [WinW-1:0] r_win;
  logic [WinW-1:0] w_win;
  logic [SetW-1:0] r_set;
  logic [SetW-1:0] w_set;
  logic            w_accept;

  assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ Poly)
                                 : (r_lfsr >> 1);

  // Gap counter holds gap-1 so that expiry lands exactly gap cycles apart
  assign w_gap_cur = GapBase + GapW'(r_lfsr[GapBits-1:0]);
  assign w_gap_nxt = GapBase + GapW'(w_lfsr_step[GapBits-1:0]);

  assign w_accept    = cmd_valid_i && (r_state == IDLE);
  assign cmd_ready_o = (r_state == IDLE);
  assign busy_o      = (r_state != IDLE);
  assign sw_o        = r_sw;
  assign done_tick_o = r_done;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Datapath registers: switch line, target, LFSR and counters
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sw   <= 1'b0;
      r_tgt  <= 1'b0;
      r_done <= 1'b0;
      r_lfsr <= SeedEff;
      r_gap  <= '0;
      r_win  <= '0;
      r_set  <= '0;
    end else begin
      r_sw   <= w_sw;
      r_tgt  <= w_tgt;
      r_done <= w_done;
      r_lfsr <= w_lfsr;
      r_gap  <= w_gap;
      r_win  <= w_win;
      r_set  <= w_set;
    end
  end

  // Next-state and next-datapath decode
  always_comb begin
    w_state = r_state;
    w_sw    = r_sw;
    w_tgt   = r_tgt;
    w_done  = 1'b0;
    w_lfsr  = r_lfsr;
    w_gap   = r_gap;
    w_win   = r_win;
    w_set   = r_set;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (cmd_level_i == r_sw) begin
            w_done = 1'b1;
          end else begin
            w_tgt   = cmd_level_i;
            w_sw    = ~r_sw;
            w_gap   = w_gap_cur;
            w_win   = WinW'(1);
            w_set   = '0;
            w_state = BOUNCE;
          end
        end
      end
      BOUNCE: begin
        // Window close wins over a coincident gap expiry
        if (r_win == WinLast) begin
          w_sw    = r_tgt;
          w_set   = '0;
          w_state = SETTLE;
        end else begin
          w_win = r_win + WinW'(1);
          if (r_gap == '0) begin
            w_sw   = ~r_sw;
            w_lfsr = w_lfsr_step;
            w_gap  = w_gap_nxt;
          end else begin
            w_gap = r_gap - GapW'(1);
          end
        end
      end
      SETTLE: begin
        if (r_set == SetLast) begin
          w_done  = 1'b1;
          w_state = IDLE;
        end else begin
          w_set = r_set + SetW'(1);
        end
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Directed bench for bounce_gen: reset, bounce timing against an
// LFSR reference, same-level, back-to-back, mid-bounce reset, debounce.
module tb_bounce_gen;

  localparam int MinGap = 4;
  localparam int Stable = 20;
  localparam logic [15:0] Seed = 16'hACE1;

  logic clk;
  logic rst_n;
  logic cmd_valid;
  logic cmd_level;
  logic cmd_ready;
  logic sw_o;
  logic busy;
  logic done;

  int n_cmp;
  int n_err;
  logic [15:0] m_lfsr;
  logic m_sw;

  int db_cnt;
  int db_ticks;
  logic db_level;

  bounce_gen #(
    .ClkFreq (1_000_000),
    .BounceUs(100),
    .SettleUs(50),
    .MinGap  (4),
    .GapBits (3),
    .Seed    (Seed)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_level_i(cmd_level),
    .cmd_ready_o(cmd_ready),
    .sw_o       (sw_o),
    .busy_o     (busy),
    .done_tick_o(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple debouncer fed from sw_o
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt   <= 0;
      db_level <= 1'b0;
    end else if (sw_o == db_level) begin
      db_cnt <= 0;
    end else if (db_cnt == Stable - 1) begin
      db_level <= sw_o;
      db_ticks <= db_ticks + 1;
      db_cnt   <= 0;
    end else begin
      db_cnt <= db_cnt + 1;
    end
  end

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  task automatic test_reset();
    cmd_valid = 1'b0;
    cmd_level = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sw_o, busy, done, cmd_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_async got=%b want=0001",
               {sw_o, busy, done, cmd_ready});
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({sw_o, busy, done, cmd_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL rst_release got=%b want=0001",
               {sw_o, busy, done, cmd_ready});
    end
    m_lfsr = Seed;
    m_sw = 1'b0;
  endtask

  // Entered #1 after an edge with the DUT idle; that cycle is cycle 0
  task automatic run_bounce(input logic lvl, input bit hold);
    bit tog [0:151];
    int t, g, ntog_m, nobs, last, db0;
    logic exp, prev;
    logic [15:0] l;
    for (int i = 0; i < 152; i++) tog[i] = 1'b0;
    tog[1] = 1'b1;
    ntog_m = 1;
    t = 1;
    l = m_lfsr;
    g = MinGap + int'(l[2:0]);
    while (t + g <= 99) begin
      t = t + g;
      tog[t] = 1'b1;
      ntog_m++;
      l = lstep(l);
      g = MinGap + int'(l[2:0]);
    end
    m_lfsr = l;
    db0 = db_ticks;
    exp = m_sw;
    prev = m_sw;
    nobs = 0;
    last = 0;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_c0 got=%b want=1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_level = lvl;
    for (int c = 1; c <= 151; c++) begin
      @(posedge clk); #1;
      if (!hold) cmd_valid = 1'b0;
      if (hold && c == 50) cmd_level = ~lvl;
      if (tog[c]) exp = ~exp;
      if (c == 100) exp = lvl;
      n_cmp++;
      if (sw_o !== exp) begin
        n_err++;
        $display("FAIL sw c=%0d got=%b want=%b", c, sw_o, exp);
      end
      n_cmp++;
      if (busy !== (c <= 150)) begin
        n_err++;
        $display("FAIL busy c=%0d got=%b want=%b", c, busy, c <= 150);
      end
      n_cmp++;
      if (done !== (c == 151)) begin
        n_err++;
        $display("FAIL done c=%0d got=%b want=%b", c, done, c == 151);
      end
      n_cmp++;
      if (cmd_ready !== (c == 151)) begin
        n_err++;
        $display("FAIL ready c=%0d got=%b want=%b",
                 c, cmd_ready, c == 151);
      end
      if (c <= 99 && sw_o !== prev) begin
        nobs++;
        if (last != 0) begin
          n_cmp++;
          if (c - last < 4 || c - last > 11) begin
            n_err++;
            $display("FAIL gap c=%0d got=%0d want=4..11", c, c - last);
          end
        end
        last = c;
      end
      prev = sw_o;
    end
    m_sw = lvl;
    n_cmp++;
    if (nobs != ntog_m) begin
      n_err++;
      $display("FAIL toggles got=%0d want=%0d", nobs, ntog_m);
    end
    n_cmp++;
    if (db_ticks != db0 + 1) begin
      n_err++;
      $display("FAIL db_ticks got=%0d want=%0d", db_ticks - db0, 1);
    end
    n_cmp++;
    if (db_level !== lvl) begin
      n_err++;
      $display("FAIL db_level got=%b want=%b", db_level, lvl);
    end
  endtask

  task automatic test_bounce();
    run_bounce(1'b1, 1'b0);
  endtask

  task automatic test_same_level();
    int db0;
    db0 = db_ticks;
    cmd_valid = 1'b1;
    cmd_level = m_sw;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if ({sw_o, busy, done, cmd_ready} !== {m_sw, 3'b011}) begin
      n_err++;
      $display("FAIL same_c1 got=%b want=%b",
               {sw_o, busy, done, cmd_ready}, {m_sw, 3'b011});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({sw_o, busy, done, cmd_ready} !== {m_sw, 3'b001}) begin
      n_err++;
      $display("FAIL same_c2 got=%b want=%b",
               {sw_o, busy, done, cmd_ready}, {m_sw, 3'b001});
    end
    n_cmp++;
    if (db_ticks != db0) begin
      n_err++;
      $display("FAIL same_db got=%0d want=0", db_ticks - db0);
    end
  endtask

  task automatic test_back_to_back();
    run_bounce(~m_sw, 1'b1);
    run_bounce(~m_sw, 1'b0);
  endtask

  task automatic test_reset_mid_bounce();
    cmd_valid = 1'b1;
    cmd_level = ~m_sw;
    repeat (40) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sw_o, busy, done, cmd_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_rst got=%b want=0001",
               {sw_o, busy, done, cmd_ready});
    end
    @(negedge clk) rst_n = 1'b1;
    m_lfsr = Seed;
    m_sw = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if ({sw_o, busy, done, cmd_ready} !== 4'b0001) begin
      n_err++;
      $display("FAIL mid_post got=%b want=0001",
               {sw_o, busy, done, cmd_ready});
    end
    run_bounce(1'b1, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    db_ticks = 0;
    test_reset();
    test_bounce();
    test_same_level();
    test_back_to_back();
    test_reset_mid_bounce();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
